// File: rtl/ram_sp_bist_pkg.sv
// Shared BIST definitions for ram_sp_bist: March FSM states, background patterns
// and element direction helpers.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_DONE = 3'd5
  } bist_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic BG_ZERO  = 1'b0;
  localparam logic BG_ONE   = 1'b1;

  function automatic logic phaseDir(input bist_state_e s);
    return (s == ST_M2) ? DIR_DOWN : DIR_UP;
  endfunction

  // Background each element expects on its read; M0 never compares.
  function automatic logic expBg(input bist_state_e s);
    return (s == ST_M2) ? BG_ONE : BG_ZERO;
  endfunction

  function automatic logic wrBg(input bist_state_e s);
    return (s == ST_M1) ? BG_ONE : BG_ZERO;
  endfunction

endpackage

// File: rtl/ram_sp_bist_if.sv
// Functional/test bus of ram_sp_bist: the controller side drives the master modport,
// the RAM uses the slave modport.
interface ram_sp_bist_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              oe;
  logic              wr;
  logic              test_mode;
  logic              bist_start;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_fail;
  logic [ADDR_W-1:0] bist_fail_addr;
  logic              parity_err;

  modport master (
    output a, din, oe, wr, test_mode, bist_start,
    input  dout, bist_busy, bist_done, bist_fail, bist_fail_addr, parity_err
  );

  modport slave (
    input  a, din, oe, wr, test_mode, bist_start,
    output dout, bist_busy, bist_done, bist_fail, bist_fail_addr, parity_err
  );
endinterface

// File: rtl/ram_sp_bist_core.sv
// Storage array with a registered read port; RAM_PARITY_EN adds a stored parity bit
// and a registered read-parity check.
module ram_sp_core #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_hold,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_parErr
);
  localparam int DEPTH = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] w_wword;
  logic [WORD_W-1:0] w_rword;
  logic              w_rparErr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_parErr;

`ifdef RAM_PARITY_EN
  assign w_wword   = {^i_wdata, i_wdata};
  assign w_rparErr = w_rword[DATA_W] != (^w_rword[DATA_W-1:0]);
`else
  assign w_wword   = i_wdata;
  assign w_rparErr = 1'b0;
`endif

  assign w_rword = r_mem[i_addr];

  // The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= w_wword;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_parErr <= 1'b0;
    end else if (i_re) begin
      r_rdata  <= w_rword[DATA_W-1:0];
      r_parErr <= w_rparErr;
    end else if (!i_hold) begin
      r_rdata  <= '0;
      r_parErr <= 1'b0;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_parErr = r_parErr;
endmodule

// File: rtl/ram_sp_bist.sv
// Single-port RAM with test-mode bypass and a March BIST sharing the one port.
// Define RAM_PARITY_EN to store and check a parity bit per word.
module ram_sp_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  ram_sp_bist_if.slave bus
);
  bist_state_e       r_state;
  bist_state_e       w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_failAddr;
  logic              r_phase;
  logic              r_fail;
  logic              w_busy;
  logic              w_done;
  logic              w_accept;
  logic              w_lastAddr;
  logic              w_stepDone;
  logic              w_cmpEn;
  logic              w_miscompare;
  logic              w_we;
  logic              w_re;
  logic              w_hold;
  logic [ADDR_W-1:0] w_coreAddr;
  logic [DATA_W-1:0] w_coreWdata;
  logic [DATA_W-1:0] w_expPat;
  logic [DATA_W-1:0] w_rdata;
  logic              w_parErr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // An element ends once its last address has finished its final sub-cycle.
  always_comb begin
    w_stepDone  = (r_state == ST_M0) || r_phase;
    w_lastAddr  = (phaseDir(r_state) == DIR_DOWN) ? (r_addr == '0)
                                                  : (r_addr == ADDR_W'(DEPTH - 1));
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (bus.bist_start) w_nextState = ST_M0;
      ST_M0:   if (w_lastAddr && w_stepDone) w_nextState = ST_M1;
      ST_M1:   if (w_lastAddr && w_stepDone) w_nextState = ST_M2;
      ST_M2:   if (w_lastAddr && w_stepDone) w_nextState = ST_M3;
      ST_M3:   if (w_lastAddr && w_stepDone) w_nextState = ST_DONE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == ST_M0) || (r_state == ST_M1) ||
               (r_state == ST_M2) || (r_state == ST_M3);
    w_done   = (r_state == ST_DONE);
    w_accept = bus.bist_start && !w_busy;
    w_expPat = {DATA_W{expBg(r_state)}};
    w_cmpEn  = w_busy && (r_state != ST_M0) && r_phase;
    if (w_busy) begin
      w_coreAddr  = r_addr;
      w_coreWdata = {DATA_W{wrBg(r_state)}};
      w_we        = (r_state == ST_M0) || (r_phase && (r_state != ST_M3));
      w_re        = (r_state != ST_M0) && !r_phase;
      w_hold      = 1'b0;
    end else begin
      w_coreAddr  = bus.a;
      w_coreWdata = bus.din;
      w_we        = bus.wr && !bus.test_mode;
      w_re        = bus.oe && !bus.wr;
      w_hold      = bus.wr;
    end
  end

  // Sub-cycle 0 reads, sub-cycle 1 compares and writes back; M0 only writes.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_addr  <= '0;
      r_phase <= 1'b0;
    end else if (w_busy) begin
      if (r_state != ST_M0) r_phase <= ~r_phase;
      if (w_stepDone) begin
        if (w_lastAddr)
          r_addr <= (r_state == ST_M1) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
        else if (phaseDir(r_state) == DIR_DOWN)
          r_addr <= r_addr - 1'b1;
        else
          r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign w_miscompare = w_cmpEn && ((w_rdata != w_expPat) || w_parErr);

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_fail     <= 1'b0;
      r_failAddr <= '0;
    end else if (w_miscompare) begin
      r_fail <= 1'b1;
      if (!r_fail) r_failAddr <= r_addr;
    end
  end

  ram_sp_core #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_addr   (w_coreAddr),
    .i_wdata  (w_coreWdata),
    .i_we     (w_we),
    .i_re     (w_re),
    .i_hold   (w_hold),
    .o_rdata  (w_rdata),
    .o_parErr (w_parErr)
  );

  assign bus.dout           = bus.test_mode ? bus.din : (w_busy ? '0 : w_rdata);
  assign bus.parity_err     = w_busy ? 1'b0 : w_parErr;
  assign bus.bist_busy      = w_busy;
  assign bus.bist_done      = w_done;
  assign bus.bist_fail      = r_fail;
  assign bus.bist_fail_addr = r_failAddr;
endmodule

// File: tb/tb_ram_sp_bist.sv
// Bench for ram_sp_bist: random functional/BIST traffic checked every cycle against
// an array-based model of the RAM and the March sequence, plus directed literal checks.
module tb_ram_sp_bist;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_sp_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_sp_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nCompared = 0;
  int nMismatch = 0;

  // Model state: memory contents, whether each word is defined, and a "bad parity" flag.
  logic [DATA_W-1:0] mMem [DEPTH];
  bit                mKnown [DEPTH];
  bit                mPar [DEPTH];
  logic [DATA_W-1:0] mDout = '0;
  bit                mDoutKnown = 1'b1;
  bit                mPe = 1'b0;
  bit                mRun = 1'b0;
  bit                mDone = 1'b0;
  bit                mFail = 1'b0;
  int                mFailAddr = 0;
  int                mCyc = 0;
  logic [DATA_W-1:0] mRd = '0;
  bit                mRdBad = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) begin
    mKnown[i] = 1'b0;
    mPar[i]   = 1'b0;
    mMem[i]   = '0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One completed BIST cycle c: M0 = c<D, then three 2-cycles-per-address elements.
  task automatic marchStep();
    int c, k, addr;
    bit isM1, isM2;
    logic [DATA_W-1:0] pat;
    c = mCyc;
    if (c < DEPTH) begin
      mMem[c] = '0; mPar[c] = 1'b0; mKnown[c] = 1'b1;
    end else begin
      isM1 = (c < 3 * DEPTH);
      isM2 = (c >= 3 * DEPTH) && (c < 5 * DEPTH);
      k    = isM1 ? c - DEPTH : (isM2 ? c - 3 * DEPTH : c - 5 * DEPTH);
      addr = isM2 ? DEPTH - 1 - k / 2 : k / 2;
      pat  = isM2 ? '1 : '0;
      if (k % 2 == 0) begin
        mRd = mMem[addr]; mRdBad = mPar[addr];
      end else begin
        if ((mRd != pat) || (PARITY_ON && mRdBad)) begin
          if (!mFail) mFailAddr = addr;
          mFail = 1'b1;
        end
        if (isM1 || isM2) begin
          mMem[addr] = isM1 ? '1 : '0; mPar[addr] = 1'b0; mKnown[addr] = 1'b1;
        end
      end
    end
    mCyc++;
    if (mCyc == 7 * DEPTH) begin
      mRun = 1'b0; mDone = 1'b1; mDout = '0; mDoutKnown = 1'b1; mPe = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      if (mRun) for (int i = 0; i < DEPTH; i++) mKnown[i] = 1'b0;
      mRun = 1'b0; mDone = 1'b0; mFail = 1'b0; mFailAddr = 0;
      mDout = '0; mDoutKnown = 1'b1; mPe = 1'b0;
    end else if (mRun) begin
      marchStep();
    end else begin
      if (bus.wr) begin
        if (!bus.test_mode) begin
          mMem[bus.a] = bus.din; mPar[bus.a] = 1'b0; mKnown[bus.a] = 1'b1;
        end
      end else if (bus.oe) begin
        mDout = mMem[bus.a]; mDoutKnown = mKnown[bus.a]; mPe = mPar[bus.a];
      end else begin
        mDout = '0; mDoutKnown = 1'b1; mPe = 1'b0;
      end
      if (bus.bist_start) begin
        mRun = 1'b1; mCyc = 0; mDone = 1'b0; mFail = 1'b0; mFailAddr = 0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    checkOutput("busy", 32'(bus.bist_busy), 32'(mRun));
    checkOutput("done", 32'(bus.bist_done), 32'(mDone));
    checkOutput("fail", 32'(bus.bist_fail), 32'(mFail));
    checkOutput("fail_addr", 32'(bus.bist_fail_addr), 32'(mFailAddr));
    if (bus.test_mode)  checkOutput("dout_bypass", 32'(bus.dout), 32'(bus.din));
    else if (mRun)      checkOutput("dout_busy", 32'(bus.dout), 32'd0);
    else if (mDoutKnown) checkOutput("dout", 32'(bus.dout), 32'(mDout));
    if (mRun)            checkOutput("parity_err_busy", 32'(bus.parity_err), 32'd0);
    else if (mDoutKnown) checkOutput("parity_err", 32'(bus.parity_err), 32'(mPe));
  end

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input bit oe, input bit wr, input bit tm, input bit st);
    bus.a = a; bus.din = d; bus.oe = oe; bus.wr = wr; bus.test_mode = tm; bus.bist_start = st;
    @(negedge clk);
  endtask

  task automatic pulseStart();
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.bist_start = 1'b0;
  endtask

  task automatic randomPhase(input int n, input bit allowStart);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                      : ADDR_W'($urandom_range(0, 15));
      applyStimulus(a, DATA_W'($urandom), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                    allowStart && ($urandom_range(0, 199) == 0));
    end
    bus.bist_start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (bus.bist_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, 32'(bus.bist_busy), 32'd0);
  endtask

  // Flip stored data bit 0 behind the port's back, leaving any stored parity untouched.
  task injectFlip(input int addr);
    dut.u_core.r_mem[addr][0] <= ~dut.u_core.r_mem[addr][0];
    mMem[addr][0] = ~mMem[addr][0];
    if (PARITY_ON) mPar[addr] = ~mPar[addr];
  endtask

  initial begin
    int busyCnt;
    bus.a = '0; bus.din = '0; bus.oe = 1'b0; bus.wr = 1'b0;
    bus.test_mode = 1'b0; bus.bist_start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_dout", 32'(bus.dout), 32'd0);
    checkOutput("reset_busy", 32'(bus.bist_busy), 32'd0);
    rst = 1'b0;

    applyStimulus(7'd5, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(7'd5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_read", 32'(bus.dout), 32'h0000A5A5);
    applyStimulus(7'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_oe_low", 32'(bus.dout), 32'd0);

    applyStimulus(7'd3, 16'h0BEE, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.a = 7'd3; bus.din = 16'h1234; bus.wr = 1'b1; bus.test_mode = 1'b1;
    #1 checkOutput("t2_bypass", 32'(bus.dout), 32'h00001234);
    @(negedge clk);
    applyStimulus(7'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_blocked_write", 32'(bus.dout), 32'h00000BEE);

    randomPhase(300, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    pulseStart();
    busyCnt = 0;
    while (bus.bist_busy && busyCnt < 2000) begin
      busyCnt++;
      @(negedge clk);
    end
    checkOutput("t3_busy_cycles", 32'(busyCnt), 32'd896);
    checkOutput("t3_done", 32'(bus.bist_done), 32'd1);
    checkOutput("t3_fail", 32'(bus.bist_fail), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t3_done_held", 32'(bus.bist_done), 32'd1);
    pulseStart();
    checkOutput("t3_restart_busy", 32'(bus.bist_busy), 32'd1);
    checkOutput("t3_restart_done", 32'(bus.bist_done), 32'd0);
    waitIdle("t3_second_run_timeout");

    pulseStart();
    repeat (130) @(negedge clk);
    injectFlip(17);
    injectFlip(40);
    repeat (200) @(negedge clk);
    checkOutput("t4_fail_mid", 32'(bus.bist_fail), 32'd1);
    checkOutput("t4_fail_addr_mid", 32'(bus.bist_fail_addr), 32'd17);
    pulseStart();
    waitIdle("t4_run_timeout");
    checkOutput("t4_fail_end", 32'(bus.bist_fail), 32'd1);
    checkOutput("t4_fail_addr_end", 32'(bus.bist_fail_addr), 32'd17);

    randomPhase(200, 1'b0);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    pulseStart();
    repeat (99) @(negedge clk);
    pulseStart();
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_busy_after_rst", 32'(bus.bist_busy), 32'd0);
    checkOutput("t5_done_after_rst", 32'(bus.bist_done), 32'd0);
    checkOutput("t5_fail_after_rst", 32'(bus.bist_fail), 32'd0);

    randomPhase(200, 1'b0);
    applyStimulus(7'd9, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    injectFlip(9);
    applyStimulus(7'd9, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_dout", 32'(bus.dout), 32'd0);
    checkOutput("t6_parity_err", 32'(bus.parity_err), PARITY_ON ? 32'd1 : 32'd0);

    randomPhase(600, 1'b1);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitIdle("final_idle_timeout");
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
